// File: rtl/green_exec_unit.sv
// green_exec_unit -- multi-cycle execute unit with an internal single-port RAM
// and an internal {Z,N,C} flag register. One instruction per start/done
// handshake: IDLE -> EXEC -> (MEM for loads) -> DONE -> IDLE.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      issue request, sampled only in IDLE
//   op         opcode (0 NOP, 1/2 INCA/B, 3/4 DECA/B, 5/6 LDA/B, 7/8 STA/B,
//              9 BR, A BRZ, B BRN, C BRC, D CLRF, E-F NOP)
//   addr       RAM address / branch target
//   a_in,b_in  operands, captured on acceptance
//   busy       high from the cycle after acceptance through the done cycle
//   done       one-cycle completion pulse
//   a_out,b_out registered results, held until the next done
//   znc        flag register {Z,N,C}
//   br_taken   branch condition held for the last completed op
//   br_target  target of the taken branch, 0 otherwise
module green_exec_unit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  a_out,
  output logic [WIDTH-1:0]  b_out,
  output logic [2:0]        znc,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target
);

  localparam logic [3:0] OP_INCA = 4'h1, OP_INCB = 4'h2;
  localparam logic [3:0] OP_DECA = 4'h3, OP_DECB = 4'h4;
  localparam logic [3:0] OP_LDA  = 4'h5, OP_LDB  = 4'h6;
  localparam logic [3:0] OP_STA  = 4'h7, OP_STB  = 4'h8;
  localparam logic [3:0] OP_BR   = 4'h9, OP_BRZ  = 4'hA;
  localparam logic [3:0] OP_BRN  = 4'hB, OP_BRC  = 4'hC;
  localparam logic [3:0] OP_CLRF = 4'hD;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam int               DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state, w_next_state;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rdata;

  logic              w_accept, w_is_load, w_is_store, w_taken;
  logic [WIDTH-1:0]  w_res_a, w_res_b;
  logic [2:0]        w_res_znc;

  function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] v, input logic c);
    return {(v == '0), v[WIDTH-1], c};
  endfunction

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_is_load  = (r_op == OP_LDA) || (r_op == OP_LDB);
  assign w_is_store = (r_op == OP_STA) || (r_op == OP_STB);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  // NOTE: default assignment first so no path leaves a variable unassigned,
  // which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = w_is_load ? S_MEM : S_DONE;
      S_MEM:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Instruction capture on acceptance; rst takes priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= '0;
      r_addr <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (w_accept) begin
      r_op   <= op;
      r_addr <= addr;
      r_a    <= a_in;
      r_b    <= b_in;
    end
  end

  // EXEC-cycle datapath for non-load ops. Branches read the flag register,
  // which cannot change between acceptance and this cycle.
  always_comb begin
    w_res_a   = r_a;
    w_res_b   = r_b;
    w_res_znc = znc;
    w_taken   = 1'b0;
    case (r_op)
      OP_INCA: begin w_res_a = r_a + ONE; w_res_znc = flags_of(w_res_a, &r_a);      end
      OP_INCB: begin w_res_b = r_b + ONE; w_res_znc = flags_of(w_res_b, &r_b);      end
      OP_DECA: begin w_res_a = r_a - ONE; w_res_znc = flags_of(w_res_a, r_a == '0); end
      OP_DECB: begin w_res_b = r_b - ONE; w_res_znc = flags_of(w_res_b, r_b == '0); end
      OP_BR:   w_taken   = 1'b1;
      OP_BRZ:  w_taken   = znc[2];
      OP_BRN:  w_taken   = znc[1];
      OP_BRC:  w_taken   = znc[0];
      OP_CLRF: w_res_znc = 3'b000;
      default: ;
    endcase
  end

  // Result registers load on the edge entering DONE so they are valid
  // during the done cycle and hold until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      b_out     <= '0;
      znc       <= 3'b000;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else if (r_state == S_EXEC && !w_is_load) begin
      a_out     <= w_res_a;
      b_out     <= w_res_b;
      znc       <= w_res_znc;
      br_taken  <= w_taken;
      br_target <= w_taken ? r_addr : '0;
    end else if (r_state == S_MEM) begin
      a_out     <= (r_op == OP_LDA) ? r_rdata : r_a;
      b_out     <= (r_op == OP_LDB) ? r_rdata : r_b;
      znc       <= flags_of(r_rdata, 1'b0);
      br_taken  <= 1'b0;
      br_target <= '0;
    end
  end

  // Single-port RAM: one access per op, in EXEC. rst gates the write so a
  // reset in a store's EXEC cycle leaves memory untouched.
  // NOTE: the array and read register are intentionally not reset; clearing
  // a RAM would prevent mapping it onto a memory macro.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_EXEC) begin
      if (w_is_store) r_mem[r_addr] <= (r_op == OP_STA) ? r_a : r_b;
      if (w_is_load)  r_rdata       <= r_mem[r_addr];
    end
  end

endmodule

// File: tb/tb_green_exec_unit.sv
module tb_green_exec_unit;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [2:0]  eznc;
    logic        ebr;
    logic [7:0]  etgt;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  op;
  logic [7:0]  addr;
  logic [15:0] a_in, b_in, a_out, b_out;
  logic        busy, done, br_taken;
  logic [2:0]  znc;
  logic [7:0]  br_target;

  // Narrow instance for the parameter sweep
  logic        s_start, s_busy, s_done, s_br;
  logic [3:0]  s_op, s_addr, s_tgt;
  logic [7:0]  s_a, s_b, s_a_out, s_b_out;
  logic [2:0]  s_znc;

  int checks = 0;
  int errors = 0;

  // Reference model state: flag register and RAM image
  logic [2:0]  m_znc;
  logic [15:0] m_mem [256];

  always #5 clk = ~clk;

  green_exec_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .a_out(a_out), .b_out(b_out), .znc(znc),
    .br_taken(br_taken), .br_target(br_target)
  );

  green_exec_unit #(.WIDTH(8), .ADDR_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(s_start), .op(s_op), .addr(s_addr),
    .a_in(s_a), .b_in(s_b), .busy(s_busy), .done(s_done),
    .a_out(s_a_out), .b_out(s_b_out), .znc(s_znc),
    .br_taken(s_br), .br_target(s_tgt)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: expectations from the opcode rules with integer arithmetic.
  task automatic model_op(inout vec_t v);
    int unsigned av, bv, r;
    av = {16'd0, v.a};
    bv = {16'd0, v.b};
    v.ea = v.a; v.eb = v.b; v.ebr = 1'b0; v.lat = 2;
    case (v.op)
      4'h1: begin r = (av + 1) % 65536;     v.ea = r[15:0]; m_znc = {r == 0, r >= 32768, av == 65535}; end
      4'h2: begin r = (bv + 1) % 65536;     v.eb = r[15:0]; m_znc = {r == 0, r >= 32768, bv == 65535}; end
      4'h3: begin r = (av + 65535) % 65536; v.ea = r[15:0]; m_znc = {r == 0, r >= 32768, av == 0}; end
      4'h4: begin r = (bv + 65535) % 65536; v.eb = r[15:0]; m_znc = {r == 0, r >= 32768, bv == 0}; end
      4'h5: begin r = {16'd0, m_mem[v.addr]}; v.ea = r[15:0]; m_znc = {r == 0, r >= 32768, 1'b0}; v.lat = 3; end
      4'h6: begin r = {16'd0, m_mem[v.addr]}; v.eb = r[15:0]; m_znc = {r == 0, r >= 32768, 1'b0}; v.lat = 3; end
      4'h7: m_mem[v.addr] = v.a;
      4'h8: m_mem[v.addr] = v.b;
      4'h9: v.ebr = 1'b1;
      4'hA: v.ebr = m_znc[2];
      4'hB: v.ebr = m_znc[1];
      4'hC: v.ebr = m_znc[0];
      4'hD: m_znc = 3'b000;
      default: ;
    endcase
    v.etgt = v.ebr ? v.addr : 8'h00;
    v.eznc = m_znc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Issue one op from IDLE, then check busy, latency, results and pulse width.
  task automatic run_op(input string name, input vec_t v);
    int lat;
    wait_idle();
    start = 1'b1; op = v.op; addr = v.addr; a_in = v.a; b_in = v.b;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); addr = 8'($urandom);
    a_in = 16'($urandom); b_in = 16'($urandom);
    check({name, " busy@k+1"}, busy, 1);
    lat = 1;
    while (!done && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, v.lat);
    if (done) begin
      check({name, " busy@done"}, busy, 1);
      check({name, " a_out"}, a_out, v.ea);
      check({name, " b_out"}, b_out, v.eb);
      check({name, " znc"}, znc, v.eznc);
      check({name, " br_taken"}, br_taken, v.ebr);
      check({name, " br_target"}, br_target, v.etgt);
      @(posedge clk); #1;
      check({name, " done pulse"}, done, 0);
      check({name, " idle after"}, busy, 0);
    end
  endtask

  task automatic run8(input logic [3:0] o, input logic [3:0] ad,
                      input logic [7:0] a, input logic [7:0] b, output int lat);
    s_start = 1'b1; s_op = o; s_addr = ad; s_a = a; s_b = b;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 1;
    while (!s_done && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t tbl [17];

  initial begin
    vec_t v;
    int   ndone, last, lat8;

    //            op    addr   a        b        ea       eb       znc     br    tgt    lat
    tbl[0]  = '{4'h1, 8'h00, 16'hFFFF, 16'h1234, 16'h0000, 16'h1234, 3'b101, 1'b0, 8'h00, 2};
    tbl[1]  = '{4'h7, 8'h10, 16'h8001, 16'h0000, 16'h8001, 16'h0000, 3'b101, 1'b0, 8'h00, 2};
    tbl[2]  = '{4'h6, 8'h10, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 3'b010, 1'b0, 8'h00, 3};
    tbl[3]  = '{4'h3, 8'h00, 16'h0000, 16'h0007, 16'hFFFF, 16'h0007, 3'b011, 1'b0, 8'h00, 2};
    tbl[4]  = '{4'hC, 8'h40, 16'h0001, 16'h0002, 16'h0001, 16'h0002, 3'b011, 1'b1, 8'h40, 2};
    tbl[5]  = '{4'hD, 8'h00, 16'h0003, 16'h0004, 16'h0003, 16'h0004, 3'b000, 1'b0, 8'h00, 2};
    tbl[6]  = '{4'hA, 8'h55, 16'h0005, 16'h0006, 16'h0005, 16'h0006, 3'b000, 1'b0, 8'h00, 2};
    tbl[7]  = '{4'h2, 8'h00, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000, 3'b010, 1'b0, 8'h00, 2};
    tbl[8]  = '{4'hB, 8'h77, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b010, 1'b1, 8'h77, 2};
    tbl[9]  = '{4'h4, 8'h00, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 3'b100, 1'b0, 8'h00, 2};
    tbl[10] = '{4'h0, 8'h00, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 3'b100, 1'b0, 8'h00, 2};
    tbl[11] = '{4'hE, 8'h33, 16'h1111, 16'h2222, 16'h1111, 16'h2222, 3'b100, 1'b0, 8'h00, 2};
    tbl[12] = '{4'h9, 8'h01, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b100, 1'b1, 8'h01, 2};
    tbl[13] = '{4'h5, 8'h10, 16'h0000, 16'hBEEF, 16'h8001, 16'hBEEF, 3'b010, 1'b0, 8'h00, 3};
    tbl[14] = '{4'h8, 8'h11, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 3'b010, 1'b0, 8'h00, 2};
    tbl[15] = '{4'h5, 8'h11, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b100, 1'b0, 8'h00, 3};
    tbl[16] = '{4'hA, 8'h22, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b100, 1'b1, 8'h22, 2};

    rst = 1'b1; start = 1'b0; op = '0; addr = '0; a_in = '0; b_in = '0;
    s_start = 1'b0; s_op = '0; s_addr = '0; s_a = '0; s_b = '0;
    m_znc = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset a_out", a_out, 0);
    check("reset b_out", b_out, 0);
    check("reset znc", znc, 0);
    check("reset br_taken", br_taken, 0);
    check("reset br_target", br_target, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table; the model runs alongside to stay in step.
    for (int i = 0; i < 17; i++) begin
      v = tbl[i];
      model_op(v);
      run_op($sformatf("vec%0d", i), tbl[i]);
    end

    // Continuous start: one INCA accepted every 3 cycles, extras ignored.
    wait_idle();
    start = 1'b1; op = 4'h1; addr = 8'h00; a_in = 16'h00FF; b_in = 16'h0000;
    ndone = 0; last = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (last > 0) check("b2b spacing", c - last, 3);
        last = c;
      end
    end
    start = 1'b0;
    check("b2b done count", ndone, 10);
    check("b2b a_out", a_out, 16'h0100);
    check("b2b znc", znc, 3'b000);
    v = '{4'h1, 8'h00, 16'h00FF, 16'h0000, 16'h0, 16'h0, 3'b0, 1'b0, 8'h0, 0};
    model_op(v);
    wait_idle();
    check("b2b idle", busy, 0);

    // Reset during the EXEC cycle of a store suppresses the write.
    v = '{4'h7, 8'h20, 16'h5555, 16'h0000, 16'h0, 16'h0, 3'b0, 1'b0, 8'h0, 0};
    model_op(v);
    run_op("sta 20", v);
    start = 1'b1; op = 4'h7; addr = 8'h20; a_in = 16'h1234; b_in = 16'h4321;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_znc = 3'b000;
    check("rst mid busy", busy, 0);
    check("rst mid done", done, 0);
    check("rst mid a_out", a_out, 0);
    check("rst mid b_out", b_out, 0);
    check("rst mid znc", znc, 0);
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("rst mid no done", ndone, 0);
    v = '{4'h5, 8'h20, 16'h0000, 16'h0F0F, 16'h0, 16'h0, 3'b0, 1'b0, 8'h0, 0};
    model_op(v);
    run_op("lda 20 after rst", v);

    // start coincident with rst is ignored.
    rst = 1'b1; start = 1'b1; op = 4'h1; a_in = 16'h0001;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    m_znc = 3'b000;
    check("start+rst busy", busy, 0);
    @(posedge clk); #1;
    check("start+rst still idle", busy, 0);
    check("start+rst no done", done, 0);

    // Randomized ops against the model; RAM window C0..C7 preloaded first.
    for (int i = 0; i < 8; i++) begin
      v = '{4'h7, 8'hC0 + 8'(i), 16'($urandom), 16'($urandom), 16'h0, 16'h0, 3'b0, 1'b0, 8'h0, 0};
      model_op(v);
      run_op("preload", v);
    end
    for (int i = 0; i < 40; i++) begin
      v.op   = 4'($urandom_range(0, 15));
      v.addr = 8'hC0 + 8'($urandom_range(0, 7));
      v.a    = 16'($urandom);
      v.b    = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v.a = 16'hFFFF;
        1: v.a = 16'h0000;
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0: v.b = 16'hFFFF;
        1: v.b = 16'h0000;
        default: ;
      endcase
      model_op(v);
      run_op($sformatf("rand%0d op%0h", i, v.op), v);
    end

    // Narrow instance: WIDTH=8, ADDR_W=4.
    run8(4'h1, 4'h0, 8'hFF, 8'h3C, lat8);
    check("w8 inca latency", lat8, 2);
    check("w8 inca a_out", s_a_out, 8'h00);
    check("w8 inca b_out", s_b_out, 8'h3C);
    check("w8 inca znc", s_znc, 3'b101);
    @(posedge clk); #1;
    run8(4'h7, 4'hF, 8'hA5, 8'h00, lat8);
    check("w8 sta latency", lat8, 2);
    @(posedge clk); #1;
    run8(4'h6, 4'hF, 8'h00, 8'h11, lat8);
    check("w8 ldb latency", lat8, 3);
    check("w8 ldb b_out", s_b_out, 8'hA5);
    check("w8 ldb znc", s_znc, 3'b010);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
